// File: rtl/x2050roar_seq.sv
// ROS address sequencer: ROAR, break-in backup, routine-entry queue, ROSDR.
// Optional ROS parity checking is enabled by defining X2050_ROS_PARITY_EN.
module x2050roar_seq #(
    parameter int AW = 13,
    parameter int RW = 19,
    parameter int DEPTH = 4,
    parameter logic [AW-1:0] ROAR_INIT = '0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ros_clock_on,
    input  logic [AW-1:0] i_next_addr,
    input  logic          i_gate_break_routine,
    input  logic          i_save_r,
    input  logic          i_break_out,
    input  logic          i_rtn_push,
    input  logic [AW-1:0] i_rtn_addr,
    output logic          o_routine_request,
    output logic          o_rtn_full,
    output logic [AW-1:0] o_ros_addr,
    input  logic [RW-1:0] i_ros_data,
`ifdef X2050_ROS_PARITY_EN
    input  logic          i_ros_par,
`endif
    output logic [AW-1:0] o_roar,
    output logic [AW-1:0] o_roar_backup,
    output logic [RW-1:0] o_rosdr,
    output logic [2:0]    o_err,
    output logic          o_par_err
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL_CNT = (IW+1)'(DEPTH);

    logic [AW-1:0] roar;
    logic [AW-1:0] roar_inc;
    logic [AW-1:0] backup;
    logic          backup_valid;
    logic [AW-1:0] q_mem [DEPTH];
    logic [AW-1:0] head_addr;
    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [IW:0]   count;
    logic [IW:0]   count_next;
    logic [RW-1:0] sense;
    logic [2:0]    err;
    logic [2:0]    err_set;
    logic          q_empty;
    logic          q_full;
    logic          pop;
    logic          push_ok;
    logic          take_break;

    always_comb begin
        roar_inc   = roar + 1'b1;
        head_addr  = q_mem[head];
        q_empty    = (count == '0);
        q_full     = (count == FULL_CNT);
        // A same-cycle save_r wins over break_out, as does a gate.
        take_break = i_break_out && !i_gate_break_routine && !i_save_r;

        o_ros_addr = i_next_addr;
        if (i_reset)
            o_ros_addr = ROAR_INIT;
        else if (i_gate_break_routine)
            o_ros_addr = q_empty ? roar_inc : head_addr;
        else if (take_break)
            o_ros_addr = backup_valid ? backup : roar_inc;

        pop        = i_ros_clock_on && i_gate_break_routine && !q_empty;
        push_ok    = i_rtn_push && (!q_full || pop);
        count_next = count + (IW+1)'(push_ok) - (IW+1)'(pop);

        err_set    = '0;
        err_set[0] = i_rtn_push && q_full && !pop;
        err_set[1] = i_gate_break_routine && q_empty;
        err_set[2] = i_break_out && !i_gate_break_routine
                     && (i_save_r || !backup_valid);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            roar              <= ROAR_INIT;
            backup            <= '0;
            backup_valid      <= 1'b0;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            sense             <= '0;
            o_routine_request <= 1'b0;
            o_rtn_full        <= 1'b0;
            err               <= '0;
        end else begin
            // Pushes are accepted even while the ROS clock is stopped.
            if (push_ok) begin
                q_mem[tail] <= i_rtn_addr;
                tail        <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            count             <= count_next;
            o_routine_request <= (count_next != '0);
            o_rtn_full        <= (count_next == FULL_CNT);
            if (i_ros_clock_on) begin
                roar  <= o_ros_addr;
                sense <= i_ros_data;
                err   <= err | err_set;
                if (i_save_r) begin
                    backup       <= roar;
                    backup_valid <= 1'b1;
                end else if (take_break) begin
                    backup_valid <= 1'b0;
                end
            end
        end
    end

`ifdef X2050_ROS_PARITY_EN
    logic par_err;

    // Odd parity over the word being latched; save cycles carry a blank word.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            par_err <= 1'b0;
        else if (i_ros_clock_on && !i_save_r && !(^{i_ros_data, i_ros_par}))
            par_err <= 1'b1;
    end

    assign o_par_err = par_err;
`else
    assign o_par_err = 1'b0;
`endif

    assign o_roar        = roar;
    assign o_roar_backup = backup;
    assign o_rosdr       = i_save_r ? '0 : sense;
    assign o_err         = err;

endmodule

// File: tb/tb_x2050roar_seq.sv
// Directed bench for x2050roar_seq: sequencing, queue, backup, clock stop.
module tb_x2050roar_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        clock_on;
    logic [12:0] next_addr;
    logic        gate;
    logic        save_r;
    logic        break_out;
    logic        rtn_push;
    logic [12:0] rtn_addr;
    logic        routine_request;
    logic        rtn_full;
    logic [12:0] ros_addr;
    logic [18:0] ros_data;
    logic [12:0] roar;
    logic [12:0] roar_backup;
    logic [18:0] rosdr;
    logic [2:0]  err;
    logic        par_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [18:0] word(input logic [12:0] a);
        return {a[5:0], a} ^ 19'h2A5A5;
    endfunction

    assign ros_data = word(ros_addr);

    x2050roar_seq dut (
        .i_clk                (clk),
        .i_reset              (reset),
        .i_ros_clock_on       (clock_on),
        .i_next_addr          (next_addr),
        .i_gate_break_routine (gate),
        .i_save_r             (save_r),
        .i_break_out          (break_out),
        .i_rtn_push           (rtn_push),
        .i_rtn_addr           (rtn_addr),
        .o_routine_request    (routine_request),
        .o_rtn_full           (rtn_full),
        .o_ros_addr           (ros_addr),
        .i_ros_data           (ros_data),
        .o_roar               (roar),
        .o_roar_backup        (roar_backup),
        .o_rosdr              (rosdr),
        .o_err                (err),
        .o_par_err            (par_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clock_on = 1'b1; next_addr = '0;
        gate = 1'b0; save_r = 1'b0; break_out = 1'b0;
        rtn_push = 1'b0; rtn_addr = '0;
        step(); step();
        check("rst_ros_addr", 32'(ros_addr), 0);
        check("rst_roar", 32'(roar), 0);
        check("rst_rosdr", 32'(rosdr), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rreq", 32'(routine_request), 0);
        check("rst_full", 32'(rtn_full), 0);
        check("rst_par", 32'(par_err), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            next_addr = 13'(i + 1);
            #1;
            check("seq_roar", 32'(roar), 32'(i));
            if (i > 0)
                check("seq_rosdr", 32'(rosdr), 32'(word(13'(i))));
            check("seq_addr", 32'(ros_addr), 32'(i + 1));
            step();
        end
        check("seq_err", 32'(err), 0);

        next_addr = 13'd6; step();
        next_addr = 13'd7; step();
        rtn_push = 1'b1; rtn_addr = 13'd100; next_addr = 13'd8; step();
        rtn_addr = 13'd110; next_addr = 13'd9; step();
        rtn_push = 1'b0;
        check("q_roar9", 32'(roar), 9);
        check("q_rreq", 32'(routine_request), 1);

        gate = 1'b1; save_r = 1'b1; next_addr = 13'd10; #1;
        check("gate1_addr", 32'(ros_addr), 100);
        check("save_blank", 32'(rosdr), 0);
        step();
        gate = 1'b0; save_r = 1'b0; next_addr = 13'd101; #1;
        check("gate1_roar", 32'(roar), 100);
        check("save_backup", 32'(roar_backup), 9);
        check("gate1_rosdr", 32'(rosdr), 32'(word(13'd100)));
        step();
        gate = 1'b1; #1;
        check("gate2_addr", 32'(ros_addr), 110);
        check("gate2_rreq", 32'(routine_request), 1);
        step();
        gate = 1'b0; #1;
        check("gate2_roar", 32'(roar), 110);
        check("drain_rreq", 32'(routine_request), 0);

        next_addr = 13'd105; step();
        break_out = 1'b1; #1;
        check("brk_addr", 32'(ros_addr), 9);
        step();
        check("brk_roar", 32'(roar), 9);
        check("brk_err", 32'(err), 0);
        check("brk2_addr", 32'(ros_addr), 10);
        step();
        break_out = 1'b0; #1;
        check("brk2_roar", 32'(roar), 10);
        check("brk2_err", 32'(err), 3'b100);

        next_addr = 13'd10;
        for (int k = 0; k < 5; k++) begin
            rtn_push = 1'b1; rtn_addr = 13'(200 + k);
            step();
            if (k == 2) check("full_k2", 32'(rtn_full), 0);
            if (k == 3) check("full_k3", 32'(rtn_full), 1);
        end
        check("ovf_err", 32'(err), 3'b101);
        rtn_addr = 13'd300; gate = 1'b1; #1;
        check("pp_addr", 32'(ros_addr), 200);
        step();
        rtn_push = 1'b0; #1;
        check("pp_roar", 32'(roar), 200);
        check("pp_full", 32'(rtn_full), 1);
        check("pp_head", 32'(ros_addr), 201);

        clock_on = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            check("frz_roar", 32'(roar), 200);
            check("frz_rosdr", 32'(rosdr), 32'(word(13'd200)));
            check("frz_addr", 32'(ros_addr), 201);
        end
        clock_on = 1'b1; step();
        check("rel_roar", 32'(roar), 201);
        check("rel_addr", 32'(ros_addr), 202);
        step(); step(); step();
        check("q_last_roar", 32'(roar), 300);
        check("q_empty_rreq", 32'(routine_request), 0);
        check("empty_addr", 32'(ros_addr), 301);
        step();
        gate = 1'b0; #1;
        check("empty_roar", 32'(roar), 301);
        check("empty_err", 32'(err), 3'b111);

        save_r = 1'b1; break_out = 1'b1; next_addr = 13'd50; #1;
        check("sb_addr", 32'(ros_addr), 50);
        check("sb_rosdr", 32'(rosdr), 0);
        step();
        save_r = 1'b0; #1;
        check("sb_backup", 32'(roar_backup), 301);
        check("sb_roar", 32'(roar), 50);
        check("sb_brk_addr", 32'(ros_addr), 301);
        step();
        break_out = 1'b0; #1;
        check("sb_brk_roar", 32'(roar), 301);

        rtn_push = 1'b1; rtn_addr = 13'd400; step();
        rtn_push = 1'b0; save_r = 1'b1; step();
        save_r = 1'b0; reset = 1'b1; gate = 1'b1; break_out = 1'b1; #1;
        check("rmb_addr", 32'(ros_addr), 0);
        step();
        reset = 1'b0; break_out = 1'b0; #1;
        check("rmb_roar", 32'(roar), 0);
        check("rmb_err", 32'(err), 0);
        check("rmb_rreq", 32'(routine_request), 0);
        check("rmb_empty_addr", 32'(ros_addr), 1);
        check("par_off", 32'(par_err), 0);
        gate = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
